uart_rx_os: RTL

Standalone 16x-oversampling UART receiver for 8N1 serial data. It is the receive end for the console transmitter path in the PDP-8 design. It delivers bytes to the CPU-side console logic through a rxRdy/rxAck handshake. Compared with the simple receive path, it adds input synchronisation, 3-sample majority voting, false-start rejection, framing error, overrun and break detection.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_gen.sv | 16 +
 rtl/uart_rx_os.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver states, oversampling constants and baud divider helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_LO = 7;
  localparam int MID_HI = 9;
  localparam int LAST_SAMPLE = 15;
  function automatic int divider(input int xtal, input int baud);
    return xtal / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle oversampling tick
module uart_baud_gen #(
  parameter int DIVIDER = 1
) (
  input  logic SYSCLK,
  input  logic RESET,
  output logic tick
);
  localparam int W = $clog2(DIVIDER + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIVIDER - 1);
  // count 0..DIVIDER-1 and wrap on the tick
  always_ff @(posedge SYSCLK)
    if (RESET) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling 8N1 receiver with voting, false-start, framing, overrun and break flags
module uart_rx_os import uart_pkg::*; #(
  parameter int XTAL = 100_000_000,
  parameter int BAUD = 9600,
  parameter int DIVIDER = divider(XTAL, BAUD)
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxRdy,
  input  logic       rxAck,
  output logic       frameErr,
  output logic       overrun,
  output logic       rxBreak
);
  state_t state, stateNext;
  logic [1:0] sync, syncVld;
  logic [3:0] sCnt;
  logic [2:0] bitIdx, smp;
  logic [7:0] shift;
  logic rxS, tick, armed, done, shiftEn, majNow, majHeld;
  assign rxS = sync[1];
  assign majNow = (smp[0] & smp[1]) | (rxS & (smp[0] | smp[1]));
  assign majHeld = (smp[0] & smp[1]) | (smp[2] & (smp[0] | smp[1]));
  uart_baud_gen #(.DIVIDER(DIVIDER)) baudGen (
    .SYSCLK(SYSCLK),
    .RESET(RESET),
    .tick(tick)
  );
  // next-state and per-tick control strobes
  always_comb begin
    stateNext = state;
    done = 1'b0;
    shiftEn = 1'b0;
    if (tick)
      case (state)
        IDLE:  if (!rxS && armed) stateNext = START;
        START: if (sCnt == 4'(MID_HI) && majNow) stateNext = IDLE;
               else if (sCnt == 4'(LAST_SAMPLE)) stateNext = DATA;
        DATA:  if (sCnt == 4'(LAST_SAMPLE)) begin
                 shiftEn = 1'b1;
                 if (bitIdx == 3'd7) stateNext = STOP;
               end
        STOP:  if (sCnt == 4'(MID_HI)) begin
                 done = 1'b1;
                 stateNext = IDLE;
               end
        default: stateNext = IDLE;
      endcase
  end
  // state register
  always_ff @(posedge SYSCLK)
    if (RESET) state <= IDLE;
    else state <= stateNext;
  // synchroniser, sampling, shift register and host-visible flags; syncVld keeps the
  // reset-preset synchroniser ones from arming the receiver before the real line is seen
  always_ff @(posedge SYSCLK)
    if (RESET) begin
      sync <= 2'b11;
      syncVld <= '0;
      armed <= 1'b0;
      sCnt <= '0;
      bitIdx <= '0;
      smp <= '0;
      shift <= '0;
      rxData <= '0;
      rxRdy <= 1'b0;
      frameErr <= 1'b0;
      overrun <= 1'b0;
      rxBreak <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      syncVld <= {syncVld[0], 1'b1};
      armed <= (done && !majNow) ? 1'b0 : (state == IDLE && syncVld[1] && rxS) ? 1'b1 : armed;
      sCnt <= (stateNext == IDLE) ? '0 : tick ? sCnt + 1'b1 : sCnt;
      smp[0] <= (tick && sCnt == 4'(MID_LO)) ? rxS : smp[0];
      smp[1] <= (tick && sCnt == 4'(MID_LO + 1)) ? rxS : smp[1];
      smp[2] <= (tick && sCnt == 4'(MID_HI)) ? rxS : smp[2];
      bitIdx <= (state == START) ? '0 : shiftEn ? bitIdx + 1'b1 : bitIdx;
      shift <= shiftEn ? {majHeld, shift[7:1]} : shift;
      rxData <= done ? shift : rxData;
      rxRdy <= done | (rxRdy & ~rxAck);
      frameErr <= done ? ~majNow : frameErr;
      overrun <= done ? (rxRdy ? ~rxAck : overrun) : (rxRdy & rxAck) ? 1'b0 : overrun;
      rxBreak <= (done && !majNow && shift == '0) ? 1'b1 : rxS ? 1'b0 : rxBreak;
    end
endmodule
